// File: rtl/sram_req_scheduler_if.sv
// Request, read-return and SRAM command signals of the SRAM request scheduler.
// master: the scheduler itself (it masters the SRAM command port).
// slave:  the surroundings (requesters, read-data buffers, SRAM controller).
interface sram_req_scheduler_if;
  logic        w0_req_valid;
  logic        w0_req_ready;
  logic [53:0] w0_req;
  logic        w1_req_valid;
  logic        w1_req_ready;
  logic [53:0] w1_req;
  logic        r0_req_valid;
  logic        r0_req_ready;
  logic [17:0] r0_req_addr;
  logic        r1_req_valid;
  logic        r1_req_ready;
  logic [17:0] r1_req_addr;
  logic        r0_credit_return;
  logic        r1_credit_return;
  logic        r0_rdata_valid;
  logic        r1_rdata_valid;
  logic [31:0] rdata;
  logic        sram_addr_valid;
  logic        sram_ready;
  logic [17:0] sram_addr;
  logic [31:0] sram_data_in;
  logic [3:0]  sram_write_mask;
  logic [31:0] sram_data_out;
  logic        sram_data_out_valid;
  logic        stray_data;

  modport master (
    input  w0_req_valid, w0_req, w1_req_valid, w1_req,
    input  r0_req_valid, r0_req_addr, r1_req_valid, r1_req_addr,
    input  r0_credit_return, r1_credit_return,
    input  sram_ready, sram_data_out, sram_data_out_valid,
    output w0_req_ready, w1_req_ready, r0_req_ready, r1_req_ready,
    output r0_rdata_valid, r1_rdata_valid, rdata,
    output sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    output stray_data
  );

  modport slave (
    output w0_req_valid, w0_req, w1_req_valid, w1_req,
    output r0_req_valid, r0_req_addr, r1_req_valid, r1_req_addr,
    output r0_credit_return, r1_credit_return,
    output sram_ready, sram_data_out, sram_data_out_valid,
    input  w0_req_ready, w1_req_ready, r0_req_ready, r1_req_ready,
    input  r0_rdata_valid, r1_rdata_valid, rdata,
    input  sram_addr_valid, sram_addr, sram_data_in, sram_write_mask,
    input  stray_data
  );
endinterface

// File: rtl/sram_req_scheduler.sv
// Round-robin scheduler sharing one SRAM command port between two writers and
// two readers. Readers are throttled by downstream credits and by the number
// of reads in flight; a tag FIFO steers each returned word to its reader.
module sram_req_scheduler #(
  parameter int CREDITS   = 8,
  parameter int TAG_DEPTH = 8
) (
  input logic                  sram_clock,
  input logic                  reset_n,
  sram_req_scheduler_if.master bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int NW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {
    PORT_W0 = 2'd0,
    PORT_W1 = 2'd1,
    PORT_R0 = 2'd2,
    PORT_R1 = 2'd3
  } port_e;

  // Command register and scheduler state
  logic          cmd_valid;
  logic [17:0]   cmd_addr;
  logic [31:0]   cmd_data;
  logic [3:0]    cmd_mask;
  logic          cmd_tag;
  port_e         rr_ptr;
  logic [CW-1:0] credit_0;
  logic [CW-1:0] credit_1;
  logic          tag_mem [TAG_DEPTH];
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;
  logic [NW-1:0] tag_count;
  logic          stray;

  logic          can_load;
  logic          cmd_is_read;
  logic [NW-1:0] inflight;
  logic          tag_room;
  logic          tag_push;
  logic          tag_pop;
  logic [3:0]    eligible;
  logic [3:0]    grant_vec;
  logic          grant_any;
  port_e         grant_port;
  logic [1:0]    cand;

  // A held read command already counts against the in-flight limit.
  assign can_load    = !cmd_valid || bus.sram_ready;
  assign cmd_is_read = cmd_valid && (cmd_mask == 4'b0000);
  assign inflight    = tag_count + NW'(cmd_is_read);
  assign tag_room    = inflight < NW'(TAG_DEPTH);
  assign tag_push    = cmd_is_read && bus.sram_ready;
  assign tag_pop     = bus.sram_data_out_valid && (tag_count != '0);

  assign eligible[PORT_W0] = bus.w0_req_valid;
  assign eligible[PORT_W1] = bus.w1_req_valid;
  assign eligible[PORT_R0] = bus.r0_req_valid && (credit_0 != '0) && tag_room;
  assign eligible[PORT_R1] = bus.r1_req_valid && (credit_1 != '0) && tag_room;

  // Round-robin search from rr_ptr; scanning backwards lets the nearest win.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = rr_ptr;
    cand       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr + 2'(i);
      if (eligible[cand]) begin
        grant_any  = 1'b1;
        grant_port = port_e'(cand);
      end
    end
    if (!(can_load && reset_n)) grant_any = 1'b0;
  end

  assign grant_vec = grant_any ? (4'b0001 << grant_port) : 4'b0000;

  assign bus.w0_req_ready    = grant_vec[PORT_W0];
  assign bus.w1_req_ready    = grant_vec[PORT_W1];
  assign bus.r0_req_ready    = grant_vec[PORT_R0];
  assign bus.r1_req_ready    = grant_vec[PORT_R1];
  assign bus.sram_addr_valid = cmd_valid;
  assign bus.sram_addr       = cmd_addr;
  assign bus.sram_data_in    = cmd_data;
  assign bus.sram_write_mask = cmd_mask;
  assign bus.rdata           = bus.sram_data_out;
  assign bus.r0_rdata_valid  = reset_n && tag_pop && !tag_mem[tag_rd_ptr];
  assign bus.r1_rdata_valid  = reset_n && tag_pop && tag_mem[tag_rd_ptr];
  assign bus.stray_data      = stray;

  // Load the granted request into the command register and advance the pointer.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge sram_clock) begin
    if (!reset_n) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      cmd_mask  <= '0;
      cmd_tag   <= 1'b0;
      rr_ptr    <= PORT_W0;
    end else if (can_load) begin
      cmd_valid <= 1'b0;
      if (grant_any) begin
        rr_ptr <= port_e'(grant_port + 2'd1);
        unique case (grant_port)
          PORT_W0: begin
            cmd_valid <= (bus.w0_req[53:50] != 4'b0000);
            cmd_mask  <= bus.w0_req[53:50];
            cmd_addr  <= bus.w0_req[49:32];
            cmd_data  <= bus.w0_req[31:0];
          end
          PORT_W1: begin
            cmd_valid <= (bus.w1_req[53:50] != 4'b0000);
            cmd_mask  <= bus.w1_req[53:50];
            cmd_addr  <= bus.w1_req[49:32];
            cmd_data  <= bus.w1_req[31:0];
          end
          PORT_R0: begin
            cmd_valid <= 1'b1;
            cmd_mask  <= 4'b0000;
            cmd_addr  <= bus.r0_req_addr;
            cmd_data  <= '0;
            cmd_tag   <= 1'b0;
          end
          PORT_R1: begin
            cmd_valid <= 1'b1;
            cmd_mask  <= 4'b0000;
            cmd_addr  <= bus.r1_req_addr;
            cmd_data  <= '0;
            cmd_tag   <= 1'b1;
          end
        endcase
      end
    end
  end

  // A grant and a return in the same cycle cancel; a return at full saturates.
  function automatic logic [CW-1:0] next_credit(input logic [CW-1:0] cur,
                                                input logic take, input logic ret);
    logic give;
    give = ret && ((cur != CW'(CREDITS)) || take);
    case ({take, give})
      2'b10:   return cur - CW'(1);
      2'b01:   return cur + CW'(1);
      default: return cur;
    endcase
  endfunction

  // Per-reader credit counters.
  always_ff @(posedge sram_clock) begin
    if (!reset_n) begin
      credit_0 <= CW'(CREDITS);
      credit_1 <= CW'(CREDITS);
    end else begin
      credit_0 <= next_credit(credit_0, grant_vec[PORT_R0], bus.r0_credit_return);
      credit_1 <= next_credit(credit_1, grant_vec[PORT_R1], bus.r1_credit_return);
    end
  end

  // Tag storage written when the controller accepts a read.
  // NOTE: no reset on the tag storage; the reset pointers and count define validity.
  always_ff @(posedge sram_clock) begin
    if (tag_push) tag_mem[tag_wr_ptr] <= cmd_tag;
  end

  // Tag FIFO pointers, occupancy and the sticky stray-return flag.
  always_ff @(posedge sram_clock) begin
    if (!reset_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
      stray      <= 1'b0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + PW'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + PW'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_count <= tag_count + NW'(1);
        2'b01:   tag_count <= tag_count - NW'(1);
        default: tag_count <= tag_count;
      endcase
      if (bus.sram_data_out_valid && (tag_count == '0)) stray <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_req_scheduler.sv
// Self-checking bench for sram_req_scheduler: directed scenarios followed by a
// randomized run, all compared each cycle against a queue-based reference model.
module tb_sram_req_scheduler;
  localparam int CREDITS   = 8;
  localparam int TAG_DEPTH = 8;

  logic sram_clock = 1'b0;
  logic reset_n    = 1'b0;
  always #5 sram_clock = ~sram_clock;

  sram_req_scheduler_if bus ();

  sram_req_scheduler #(.CREDITS(CREDITS), .TAG_DEPTH(TAG_DEPTH)) dut (
    .sram_clock (sram_clock),
    .reset_n    (reset_n),
    .bus        (bus.master)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: command slot, pointer, credits and a queue of read tags.
  bit          m_valid;
  logic [17:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  int          m_tag;
  int          m_ptr;
  int          m_credit [2];
  int          m_tags [$];
  bit          m_stray;
  bit          auto_ret = 1'b0;

  // DUT outputs as sampled at the last negedge.
  int          obs_grant;
  bit          obs_r0v, obs_r1v, obs_stray, obs_av;
  logic [31:0] obs_rdata, obs_data;
  logic [17:0] obs_addr;
  logic [3:0]  obs_mask;

  logic [3:0]  t1_masks [4] = '{4'hF, 4'h3, 4'h0, 4'h0};
  int          reads, writes;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_mask    = '0;
    m_tag     = 0;
    m_ptr     = 0;
    m_credit[0] = CREDITS;
    m_credit[1] = CREDITS;
    m_tags.delete();
    m_stray   = 1'b0;
  endtask

  task automatic idle();
    bus.w0_req_valid        = 1'b0;
    bus.w1_req_valid        = 1'b0;
    bus.r0_req_valid        = 1'b0;
    bus.r1_req_valid        = 1'b0;
    bus.r0_credit_return    = 1'b0;
    bus.r1_credit_return    = 1'b0;
    bus.sram_data_out_valid = 1'b0;
    bus.sram_ready          = 1'b1;
  endtask

  // One clock: compare at negedge, then advance the model at the posedge.
  task automatic step();
    bit          can_load;
    bit          elig [4];
    int          inflight, g, head;
    logic [53:0] wreq;
    logic [3:0]  rdy;
    bit          took, ret;
    if (auto_ret) begin
      bus.sram_data_out_valid = (m_tags.size() > 0);
      bus.sram_data_out       = $urandom;
    end
    @(negedge sram_clock);
    can_load = !m_valid || bus.sram_ready;
    inflight = m_tags.size() + ((m_valid && m_mask == 4'b0000) ? 1 : 0);
    elig[0] = bus.w0_req_valid;
    elig[1] = bus.w1_req_valid;
    elig[2] = bus.r0_req_valid && m_credit[0] > 0 && inflight < TAG_DEPTH;
    elig[3] = bus.r1_req_valid && m_credit[1] > 0 && inflight < TAG_DEPTH;
    g = -1;
    if (reset_n && can_load)
      for (int i = 0; i < 4; i++)
        if (g < 0 && elig[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
    head = (reset_n && bus.sram_data_out_valid && m_tags.size() > 0) ? m_tags[0] : -1;

    rdy = {bus.r1_req_ready, bus.r0_req_ready, bus.w1_req_ready, bus.w0_req_ready};
    obs_grant = -1;
    for (int p = 0; p < 4; p++) if (rdy[p]) obs_grant = p;
    obs_av    = bus.sram_addr_valid;
    obs_addr  = bus.sram_addr;
    obs_data  = bus.sram_data_in;
    obs_mask  = bus.sram_write_mask;
    obs_r0v   = bus.r0_rdata_valid;
    obs_r1v   = bus.r1_rdata_valid;
    obs_rdata = bus.rdata;
    obs_stray = bus.stray_data;

    for (int p = 0; p < 4; p++) check($sformatf("req_ready_%0d", p), rdy[p], g == p);
    check("single_ready", $countones(rdy) <= 1, 1'b1);
    check("sram_addr_valid", obs_av, m_valid);
    if (m_valid) begin
      check("sram_addr", obs_addr, m_addr);
      check("sram_data_in", obs_data, m_data);
      check("sram_write_mask", obs_mask, m_mask);
    end
    check("r0_rdata_valid", obs_r0v, head == 0);
    check("r1_rdata_valid", obs_r1v, head == 1);
    check("rdata", obs_rdata, bus.sram_data_out);
    check("stray_data", obs_stray, m_stray);

    @(posedge sram_clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (bus.sram_data_out_valid) begin
        if (m_tags.size() > 0) void'(m_tags.pop_front());
        else m_stray = 1'b1;
      end
      if (m_valid && bus.sram_ready && m_mask == 4'b0000) m_tags.push_back(m_tag);
      for (int k = 0; k < 2; k++) begin
        took = (g == 2 + k);
        ret  = (k == 0) ? bus.r0_credit_return : bus.r1_credit_return;
        if (took && !ret) m_credit[k]--;
        else if (!took && ret && m_credit[k] < CREDITS) m_credit[k]++;
      end
      if (can_load) begin
        if (g < 0) begin
          m_valid = 1'b0;
        end else begin
          if (g < 2) begin
            wreq    = (g == 0) ? bus.w0_req : bus.w1_req;
            m_mask  = wreq[53:50];
            m_addr  = wreq[49:32];
            m_data  = wreq[31:0];
            m_valid = (m_mask != 4'b0000);
          end else begin
            m_valid = 1'b1;
            m_mask  = 4'b0000;
            m_data  = '0;
            m_tag   = g - 2;
            m_addr  = (g == 2) ? bus.r0_req_addr : bus.r1_req_addr;
          end
          m_ptr = (g + 1) % 4;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    idle();
    auto_ret = 1'b0;
    reset_n  = 1'b0;
    step();
    reset_n  = 1'b1;
  endtask

  initial begin
    idle();
    bus.w0_req = '0; bus.w1_req = '0; bus.r0_req_addr = '0; bus.r1_req_addr = '0;
    bus.sram_data_out = '0;
    repeat (2) @(posedge sram_clock);
    #1;
    model_reset();
    reset_n = 1'b1;

    // Reset values of the command outputs
    step();
    check("rst_addr_valid", obs_av, 1'b0);
    check("rst_addr", obs_addr, 18'h0);
    check("rst_mask", obs_mask, 4'h0);
    check("rst_stray", obs_stray, 1'b0);

    // All four ports contending: strict W0, W1, R0, R1 rotation
    apply_reset();
    bus.w0_req = {4'hF, 18'h00001, 32'h1111_1111};
    bus.w1_req = {4'h3, 18'h00002, 32'h2222_2222};
    bus.r0_req_addr = 18'h00003;
    bus.r1_req_addr = 18'h00004;
    bus.w0_req_valid = 1'b1; bus.w1_req_valid = 1'b1;
    bus.r0_req_valid = 1'b1; bus.r1_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("t1_grant_order", obs_grant, i % 4);
      if (i > 0) check("t1_mask", obs_mask, t1_masks[(i - 1) % 4]);
    end

    // R0 alone: credits limit it to 8 reads, one credit return allows one more
    apply_reset();
    auto_ret = 1'b1;
    bus.r0_req_valid = 1'b1;
    bus.r0_req_addr  = 18'h00123;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_grant == 2) reads++;
    end
    check("t2_reads_on_credits", reads, 8);
    check("t2_blocked", obs_grant, -1);
    bus.r0_credit_return = 1'b1;
    step();
    reads = (obs_grant == 2) ? 1 : 0;
    bus.r0_credit_return = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_grant == 2) reads++;
    end
    check("t2_reads_after_return", reads, 1);

    // Read data is steered to the issuing port in order
    apply_reset();
    bus.r0_req_valid = 1'b1; bus.r0_req_addr = 18'h00010;
    step();
    check("t3_r0_grant", obs_grant, 2);
    bus.r0_req_valid = 1'b0;
    bus.r1_req_valid = 1'b1; bus.r1_req_addr = 18'h00020;
    step();
    check("t3_r1_grant", obs_grant, 3);
    check("t3_r0_cmd_addr", obs_addr, 18'h00010);
    bus.r1_req_valid = 1'b0;
    step();
    check("t3_r1_cmd_addr", obs_addr, 18'h00020);
    step();
    step();
    bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'hAAAA_0000;
    step();
    check("t3_r0_valid", obs_r0v, 1'b1);
    check("t3_r0_data", obs_rdata, 32'hAAAA_0000);
    bus.sram_data_out = 32'hBBBB_0000;
    step();
    check("t3_r1_valid", obs_r1v, 1'b1);
    check("t3_r1_data", obs_rdata, 32'hBBBB_0000);
    bus.sram_data_out_valid = 1'b0;
    step();
    check("t3_no_stray", obs_stray, 1'b0);

    // Controller stall holds the command stable and blocks further grants
    apply_reset();
    bus.sram_ready   = 1'b0;
    bus.w1_req       = {4'b1111, 18'h3FFFF, 32'hDEAD_BEEF};
    bus.w1_req_valid = 1'b1;
    step();
    check("t4_w1_grant", obs_grant, 1);
    bus.w1_req_valid = 1'b0;
    bus.w0_req_valid = 1'b1; bus.w0_req = {4'h5, 18'h00777, 32'h0BAD_F00D};
    bus.r0_req_valid = 1'b1; bus.r0_req_addr = 18'h00055;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_no_grant", obs_grant, -1);
      check("t4_hold_addr", obs_addr, 18'h3FFFF);
      check("t4_hold_data", obs_data, 32'hDEAD_BEEF);
      check("t4_hold_mask", obs_mask, 4'hF);
    end
    bus.sram_ready = 1'b1;
    step();
    check("t4_next_grant", obs_grant, 2);
    step();
    check("t4_r0_cmd_addr", obs_addr, 18'h00055);

    // In-flight limit: reads stop at 8 outstanding, writes keep flowing
    apply_reset();
    bus.w0_req_valid = 1'b1; bus.w0_req = {4'h1, 18'h00100, 32'h5555_AAAA};
    bus.r0_req_valid = 1'b1; bus.r0_req_addr = 18'h00200;
    bus.r1_req_valid = 1'b1; bus.r1_req_addr = 18'h00300;
    reads = 0; writes = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs_grant >= 2) reads++;
      if (i >= 20 && obs_grant == 0) writes++;
    end
    check("t5_reads_in_flight", reads, TAG_DEPTH);
    check("t5_writes_continue", writes, 10);
    bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'h0000_0001;
    step();
    check("t5_return_steered", obs_r0v || obs_r1v, 1'b1);
    reads = (obs_grant >= 2) ? 1 : 0;
    bus.sram_data_out_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_grant >= 2) reads++;
    end
    check("t5_one_more_read", reads, 1);

    // Stray return, then reset with reads in flight
    apply_reset();
    bus.sram_data_out_valid = 1'b1; bus.sram_data_out = 32'h1234_5678;
    step();
    check("t6_no_rdata_valid", {obs_r0v, obs_r1v}, 2'b00);
    bus.sram_data_out_valid = 1'b0;
    step();
    check("t6_stray_set", obs_stray, 1'b1);
    bus.r0_req_valid = 1'b1; bus.r0_req_addr = 18'h00042;
    repeat (3) step();
    bus.r0_req_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("t6_stray_clear", obs_stray, 1'b0);
    check("t6_addr_valid_clear", obs_av, 1'b0);
    check("t6_addr_clear", obs_addr, 18'h0);
    check("t6_data_clear", obs_data, 32'h0);
    bus.w0_req_valid = 1'b1; bus.w0_req = {4'h8, 18'h00009, 32'h0000_0009};
    bus.w1_req_valid = 1'b1; bus.r0_req_valid = 1'b1; bus.r1_req_valid = 1'b1;
    step();
    check("t6_ptr_w0", obs_grant, 0);
    idle();
    step();
    bus.sram_data_out_valid = 1'b1;
    step();
    check("t6_late_return_dropped", {obs_r0v, obs_r1v}, 2'b00);
    bus.sram_data_out_valid = 1'b0;
    step();
    check("t6_late_return_stray", obs_stray, 1'b1);
    auto_ret = 1'b1;
    bus.r0_req_valid = 1'b1;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (obs_grant == 2) reads++;
    end
    check("t6_credits_restored", reads, CREDITS);

    // Randomized traffic with occasional resets
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      bus.w0_req_valid = 1'($urandom_range(0, 1));
      bus.w1_req_valid = 1'($urandom_range(0, 1));
      bus.r0_req_valid = 1'($urandom_range(0, 1));
      bus.r1_req_valid = 1'($urandom_range(0, 1));
      bus.w0_req = {4'($urandom_range(0, 15)), 18'($urandom), 32'($urandom)};
      bus.w1_req = {4'($urandom_range(0, 15)), 18'($urandom), 32'($urandom)};
      bus.r0_req_addr = 18'($urandom);
      bus.r1_req_addr = 18'($urandom);
      bus.sram_ready = ($urandom_range(0, 9) < 7);
      bus.r0_credit_return = ($urandom_range(0, 4) == 0);
      bus.r1_credit_return = ($urandom_range(0, 4) == 0);
      bus.sram_data_out_valid = ($urandom_range(0, 2) == 0);
      bus.sram_data_out = $urandom;
      reset_n = ($urandom_range(0, 299) != 0);
      step();
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
